vga_plot_arbiter: RTL
=====================

// Module: vga_plot_arbiter
// PURPOSE
// - Shares the single VGA adapter plot port (160x120, 3-bit colour) between
//   NREQ drawing engines: screen clear, grid drawer, ship/shot sprite drawer.
// - Round-robin pixel arbitration, with a lock for atomic bursts (e.g. a sprite).
// - Clips off-screen pixels and drives a registered X/Y/COLOUR/PLOT.
// - Sits between the drawing FSMs and vga_adapter inside drawscreen.
// PARAMETERS
// - NREQ  3    number of requesters (2..8)
// - XW    8    x coordinate width
// - YW    7    y coordinate width
// - CW    3    colour width
// - XMAX  160  screen width; x >= XMAX is off-screen
// - YMAX  120  screen height; y >= YMAX is off-screen
// PORTS
// - CLOCK_50    in   1        system clock, rising edge
// - rst_n       in   1        asynchronous, active-low reset
// - req         in   NREQ     req[k]: requester k presents a pixel this cycle
// - lock        in   NREQ     lock[k]: keep the grant after this pixel (burst)
// - x_in        in   NREQ*XW  packed pixel x, requester k at [k*XW +: XW]
// - y_in        in   NREQ*YW  packed pixel y
// - col_in      in   NREQ*CW  packed pixel colour
// - gnt         out  NREQ     one-hot or zero; combinational from req/state
// - VGA_X       out  XW       registered pixel x to vga_adapter
// - VGA_Y       out  YW       registered pixel y
// - VGA_COLOUR  out  CW       registered pixel colour
// - VGA_PLOT    out  1        registered write strobe, high for one cycle per pixel
// - busy        out  1        high while in LOCKED
// - clip_cnt    out  16       count of clipped pixels, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async, rst_n=0), all outputs and state cleared:
//   - VGA_X/Y/COLOUR = 0, VGA_PLOT = 0, busy = 0, clip_cnt = 0
//   - state = IDLE, ptr = 0
//   - gnt = 0 while rst_n = 0
// - Handshake: a pixel from requester k is accepted in cycle t iff req[k] & gnt[k].
//   - Requesters hold req/x/y/col stable until accepted.
//   - At most one accept per cycle; throughput is 1 pixel/cycle.
// - Latency: a pixel accepted at edge t drives VGA_* with VGA_PLOT=1 after edge t.
//   - With no accept, VGA_PLOT=0 on the next cycle; X/Y/COLOUR hold their last value.
// - Clipping: an accepted pixel with x>=XMAX or y>=YMAX completes its handshake.
//   - VGA_PLOT stays 0 for it and clip_cnt increments (saturating).
// - FSM, IDLE:
//   - gnt = first set req bit scanning ptr, ptr+1, ... (mod NREQ).
//   - Accept from k with lock[k]=0: ptr <= (k+1) mod NREQ; stay IDLE.
//   - Accept from k with lock[k]=1: owner <= k; go to LOCKED; ptr unchanged.
// - FSM, LOCKED (busy=1):
//   - gnt = onehot(owner) & req[owner]; all others get 0.
//   - Accept with lock[owner]=0 (last burst pixel): ptr <= owner+1; go to IDLE.
//   - req[owner]=0 (abandoned burst): ptr <= owner+1; go to IDLE. No pixel is emitted.
// - Simultaneous events:
//   - Several req in IDLE: only the round-robin winner is granted.
//   - Losers wait; the worst-case wait with no locks is NREQ-1 pixels.
//   - Clip and saturation in the same cycle: the counter stays at FFFF.
// - Wrap-around: ptr wraps from NREQ-1 to 0; an unused NREQ index is never granted.
// - Reset mid-burst: state drops to IDLE and VGA_PLOT to 0 immediately.
//   - No partial pixel is written after rst_n deasserts.
// STRUCTURE
// - vga_pkg holds XW/YW/CW/XMAX/YMAX, the colour constants and the
//   arb_state_t enum {IDLE, LOCKED}.
// - Sub-module rr_pick: combinational round-robin priority picker.
//   - Inputs: req[NREQ] and ptr. Output: one-hot win.
//   - The top level holds the FSM, the output registers and clip_cnt.
// TESTING
// - Reset: rst_n=0 with req=3'b111 -> gnt=0, VGA_PLOT=0, clip_cnt=0;
//   first grant after release goes to req0.
// - Fairness: req=3'b111 held, lock=0 for 6 cycles
//   -> gnt sequence 001,010,100,001,010,100; VGA_PLOT high for 6 cycles, 1 cycle late.
// - Lock burst: req1 locks for 4 pixels while req0/req2 request -> gnt=010 for 4 accepts.
//   - Next grant is req2 (ptr=2); busy high for exactly those cycles.
// - Clip: req0 at (160,5) then (159,119) -> first pixel gives VGA_PLOT=0, clip_cnt=1;
//   - second gives VGA_X=159, VGA_Y=119, VGA_PLOT=1.
// - Abandon + reset: req2 locks, then drops req -> state IDLE, ptr=0.
//   - Then rst_n pulsed low mid-burst -> VGA_PLOT=0 asynchronously, busy=0.
// - Full-screen clear: one requester streams all 19200 pixels, lock=0
//   -> exactly 19200 PLOT strobes, clip_cnt=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared screen geometry, colour constants and arbiter state type for the
// drawscreen plot path.
package vga_pkg;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int XMAX = 160;
    localparam int YMAX = 120;

    localparam logic [CW-1:0] COL_BLACK  = 3'd0;
    localparam logic [CW-1:0] COL_BLUE   = 3'd1;
    localparam logic [CW-1:0] COL_GREEN  = 3'd2;
    localparam logic [CW-1:0] COL_CYAN   = 3'd3;
    localparam logic [CW-1:0] COL_RED    = 3'd4;
    localparam logic [CW-1:0] COL_PURPLE = 3'd5;
    localparam logic [CW-1:0] COL_YELLOW = 3'd6;
    localparam logic [CW-1:0] COL_WHITE  = 3'd7;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic logic on_screen(logic [XW-1:0] x, logic [YW-1:0] y);
        return (int'(x) < XMAX) && (int'(y) < YMAX);
    endfunction
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Pixel request bundle between the drawing engines (master) and the plot
// arbiter (slave); one lane per requester, coordinates packed per lane.
interface vga_plot_arbiter_if #(parameter int NREQ = 3);
    import vga_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*XW-1:0] x_in;
    logic [NREQ*YW-1:0] y_in;
    logic [NREQ*CW-1:0] col_in;
    logic [NREQ-1:0]    gnt;

    modport master (output req, lock, x_in, y_in, col_in, input gnt);
    modport slave  (input req, lock, x_in, y_in, col_in, output gnt);
endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from ptr
// upward, wrapping modulo NREQ; output is one-hot or zero.
module rr_pick #(
    parameter int  NREQ = 3,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win
);
    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the single vga_adapter plot port between NREQ drawing engines:
// round-robin per pixel, lockable bursts, off-screen clipping, registered output.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int  NREQ = 3,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    vga_plot_arbiter_if.slave    bus,
    output logic [XW-1:0]        VGA_X,
    output logic [YW-1:0]        VGA_Y,
    output logic [CW-1:0]        VGA_COLOUR,
    output logic                 VGA_PLOT,
    output logic                 busy,
    output logic [15:0]          clip_cnt
);
    arb_state_t      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] win;
    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   sel;
    logic            accept;
    logic [XW-1:0]   px_x;
    logic [YW-1:0]   px_y;
    logic [CW-1:0]   px_c;
    logic            visible;

    function automatic logic [PW-1:0] next_idx(logic [PW-1:0] k);
        return (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win)
    );

    // Grant is masked by rst_n so nothing is offered while held in reset.
    always_comb begin
        gnt_c = '0;
        if (rst_n) begin
            if (state == IDLE) gnt_c = win;
            else               gnt_c[owner] = bus.req[owner];
        end
    end
    assign bus.gnt = gnt_c;

    always_comb begin
        sel = '0;
        for (int k = 0; k < NREQ; k++)
            if (gnt_c[k]) sel = PW'(k);
    end

    assign accept  = |gnt_c;
    assign px_x    = bus.x_in[sel*XW +: XW];
    assign px_y    = bus.y_in[sel*YW +: YW];
    assign px_c    = bus.col_in[sel*CW +: CW];
    assign visible = on_screen(px_x, px_y);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOUR <= '0;
            VGA_PLOT   <= 1'b0;
            clip_cnt   <= '0;
        end else begin
            VGA_PLOT <= accept && visible;
            // Coordinates only move for pixels actually written.
            if (accept && visible) begin
                VGA_X      <= px_x;
                VGA_Y      <= px_y;
                VGA_COLOUR <= px_c;
            end
            if (accept && !visible && clip_cnt != 16'hFFFF)
                clip_cnt <= clip_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.lock[sel]) begin
                            owner <= sel;
                            state <= LOCKED;
                            busy  <= 1'b1;
                        end else begin
                            ptr <= next_idx(sel);
                        end
                    end
                end
                LOCKED: begin
                    // Leave on the last burst pixel or when the owner walks away.
                    if (!bus.req[owner] || !bus.lock[owner]) begin
                        ptr   <= next_idx(owner);
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
